// File: rtl/lift_scheduler.sv
// Elevator floor-request scheduler: latches button requests, picks the travel
// direction by SCAN, steps the car one floor at a time and runs the door handshake.
module lift_scheduler #(
  parameter int unsigned FLOORS        = 8,
  parameter int unsigned FW            = 3,
  parameter int unsigned MOVE_TIME     = 16,
  parameter int unsigned DOOR_HOLD     = 32,
  parameter int unsigned CLOSE_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] req_in,
  input  logic              close_signal,
  output logic              open_signal,
  output logic              move_up,
  output logic              move_down,
  output logic [FW-1:0]     cur_floor,
  output logic              dir_up,
  output logic [FLOORS-1:0] req_pending,
  output logic              busy
);

  localparam int unsigned MoveW = (MOVE_TIME > 1) ? $clog2(MOVE_TIME) : 1;
  localparam int unsigned HoldW = (DOOR_HOLD > 1) ? $clog2(DOOR_HOLD) : 1;
  localparam int unsigned WaitW = (CLOSE_TIMEOUT > 1) ? $clog2(CLOSE_TIMEOUT) : 1;

  localparam logic [MoveW-1:0] MoveLast = MoveW'(MOVE_TIME - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(DOOR_HOLD - 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(CLOSE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StOpen,
    StClosing,
    StDecide
  } state_e;

  state_e            state_q, state_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic              dir_q, dir_d;
  logic [FLOORS-1:0] pend_q, pend_d;
  logic [MoveW-1:0]  move_cnt_q, move_cnt_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              close_prev_q;

  logic              above, below, here;
  logic              req_here, close_fall;
  logic              scan_dir;
  logic [FW-1:0]     step_floor;
  logic [FLOORS-1:0] latch_mask;

  // Request summary relative to the car, from the registered request set only.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pend_q[i] && (FW'(i) > floor_q)) begin
        above = 1'b1;
      end
      if (pend_q[i] && (FW'(i) < floor_q)) begin
        below = 1'b1;
      end
    end
  end

  assign here       = pend_q[floor_q];
  assign req_here   = req_in[floor_q];
  assign close_fall = close_prev_q & ~close_signal;
  // Keep the current direction while work remains that way, otherwise turn toward it.
  assign scan_dir   = (dir_q ? above : below) ? dir_q : above;
  assign step_floor = dir_q ? (floor_q + FW'(1)) : (floor_q - FW'(1));

  always_comb begin
    state_d    = state_q;
    floor_d    = floor_q;
    dir_d      = dir_q;
    move_cnt_d = move_cnt_q;
    hold_cnt_d = hold_cnt_q;
    wait_cnt_d = wait_cnt_q;

    case (state_q)
      StIdle: begin
        if (here) begin
          state_d    = StOpen;
          hold_cnt_d = '0;
        end else if (above || below) begin
          state_d    = StMove;
          dir_d      = scan_dir;
          move_cnt_d = '0;
        end
      end

      StMove: begin
        if (move_cnt_q == MoveLast) begin
          move_cnt_d = '0;
          floor_d    = step_floor;
          if (pend_q[step_floor]) begin
            state_d    = StOpen;
            hold_cnt_d = '0;
          end
        end else begin
          move_cnt_d = move_cnt_q + MoveW'(1);
        end
      end

      StOpen: begin
        if (req_here) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HoldLast) begin
          state_d    = StClosing;
          hold_cnt_d = '0;
          wait_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end

      StClosing: begin
        // A button press at this floor beats a simultaneous close completion.
        if (req_here) begin
          state_d    = StOpen;
          hold_cnt_d = '0;
        end else if (close_fall) begin
          state_d    = StDecide;
        end else if (wait_cnt_q == WaitLast) begin
          state_d    = StOpen;
          hold_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WaitW'(1);
        end
      end

      StDecide: begin
        if (above || below) begin
          state_d    = StMove;
          dir_d      = scan_dir;
          move_cnt_d = '0;
        end else begin
          state_d    = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // The floor being served never latches its own button; presses there re-open the door.
  always_comb begin
    latch_mask = '1;
    if ((state_q == StOpen) || (state_q == StClosing)) begin
      latch_mask[floor_q] = 1'b0;
    end
    if (state_d == StOpen) begin
      latch_mask[floor_d] = 1'b0;
    end
    pend_d = (pend_q | req_in) & latch_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      floor_q      <= '0;
      dir_q        <= 1'b1;
      pend_q       <= '0;
      move_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      wait_cnt_q   <= '0;
      close_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      floor_q      <= floor_d;
      dir_q        <= dir_d;
      pend_q       <= pend_d;
      move_cnt_q   <= move_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
      close_prev_q <= close_signal;
    end
  end

  assign open_signal = (state_q == StOpen);
  assign move_up     = (state_q == StMove) && dir_q;
  assign move_down   = (state_q == StMove) && !dir_q;
  assign cur_floor   = floor_q;
  assign dir_up      = dir_q;
  assign req_pending = pend_q;
  assign busy        = (state_q != StIdle);

  // Motor and door drives never overlap and the car stays inside the shaft.
  drive_exclusive_a : assert property (@(posedge clk) disable iff (rst)
    $onehot0({open_signal, move_up, move_down}));
  floor_in_range_a : assert property (@(posedge clk) disable iff (rst)
    (32'(cur_floor) < FLOORS));

endmodule

// File: tb/tb_lift_scheduler.sv
// Bench for lift_scheduler: directed trip table and corner sequences, then random
// traffic, all cross-checked every cycle against a countdown-based reference model.
module tb_lift_scheduler;

  localparam int FLOORS        = 8;
  localparam int FW            = 3;
  localparam int MOVE_TIME     = 4;
  localparam int DOOR_HOLD     = 8;
  localparam int CLOSE_TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FLOORS-1:0] req_in = '0;
  logic              close_signal = 1'b0;
  logic              open_signal, move_up, move_down, dir_up, busy;
  logic [FW-1:0]     cur_floor;
  logic [FLOORS-1:0] req_pending;

  lift_scheduler #(
    .FLOORS       (FLOORS),
    .FW           (FW),
    .MOVE_TIME    (MOVE_TIME),
    .DOOR_HOLD    (DOOR_HOLD),
    .CLOSE_TIMEOUT(CLOSE_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .close_signal(close_signal),
    .open_signal (open_signal),
    .move_up     (move_up),
    .move_down   (move_down),
    .cur_floor   (cur_floor),
    .dir_up      (dir_up),
    .req_pending (req_pending),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: phase plus cycles-left countdown.
  localparam int PIdle = 0, PMove = 1, POpen = 2, PClose = 3, PDecide = 4;
  int                m_phase = PIdle;
  int                m_floor = 0;
  int                m_left  = 0;
  bit                m_up    = 1'b1;
  bit                m_prev  = 1'b0;
  logic [FLOORS-1:0] m_pend  = '0;

  task automatic model_clock(input logic [FLOORS-1:0] r, input bit c, input bit rs);
    bit above, below;
    int old_phase, old_floor;
    logic [FLOORS-1:0] np;
    if (rs) begin
      m_phase = PIdle; m_floor = 0; m_left = 0; m_up = 1'b1; m_prev = 1'b0; m_pend = '0;
      return;
    end
    above = 1'b0;
    below = 1'b0;
    for (int j = 0; j < FLOORS; j++) begin
      if (m_pend[j] && j > m_floor) above = 1'b1;
      if (m_pend[j] && j < m_floor) below = 1'b1;
    end
    old_phase = m_phase;
    old_floor = m_floor;
    np = m_pend | r;
    case (m_phase)
      PIdle: begin
        if (m_pend[m_floor]) begin
          m_phase = POpen; m_left = DOOR_HOLD;
        end else if (above || below) begin
          if (!(m_up ? above : below)) m_up = above;
          m_phase = PMove; m_left = MOVE_TIME;
        end
      end
      PMove: begin
        m_left--;
        if (m_left == 0) begin
          m_floor += m_up ? 1 : -1;
          if (m_pend[m_floor]) begin
            m_phase = POpen; m_left = DOOR_HOLD;
          end else begin
            m_left = MOVE_TIME;
          end
        end
      end
      POpen: begin
        if (r[m_floor]) begin
          m_left = DOOR_HOLD;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_phase = PClose; m_left = CLOSE_TIMEOUT;
          end
        end
      end
      PClose: begin
        if (r[m_floor]) begin
          m_phase = POpen; m_left = DOOR_HOLD;
        end else if (m_prev && !c) begin
          m_phase = PDecide;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_phase = POpen; m_left = DOOR_HOLD;
          end
        end
      end
      default: begin
        if (above || below) begin
          if (!(m_up ? above : below)) m_up = above;
          m_phase = PMove; m_left = MOVE_TIME;
        end else begin
          m_phase = PIdle;
        end
      end
    endcase
    if (old_phase == POpen || old_phase == PClose) np[old_floor] = 1'b0;
    if (m_phase == POpen) np[m_floor] = 1'b0;
    m_pend = np;
    m_prev = c;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_model();
    logic [15:0] got, exp;
    got = {open_signal, move_up, move_down, cur_floor, dir_up, req_pending, busy};
    exp = {(m_phase == POpen), (m_phase == PMove) && m_up, (m_phase == PMove) && !m_up,
           3'(m_floor), m_up, m_pend, (m_phase != PIdle)};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model cycle %0d: got %h expected %h", cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_clock(req_in, close_signal, rst);
    #1;
    cyc++;
    compare_model();
  endtask

  task automatic wait_open(input bit lvl, input int limit, input string name);
    int g;
    g = 0;
    while (open_signal !== lvl && g < limit) begin
      step();
      g++;
    end
    check(name, open_signal, lvl);
  endtask

  task automatic pulse_close();
    close_signal = 1'b1;
    repeat (5) step();
    close_signal = 1'b0;
    step();
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (busy && g < 20) begin
      step();
      g++;
    end
    check(name, busy, 0);
  endtask

  typedef struct {
    int target;
    int travel;
    bit dir;
  } trip_t;

  task automatic run_trip(input trip_t t, input int idx);
    int cnt, g;
    bit got_dir;
    req_in = FLOORS'(1 << t.target);
    step();
    req_in = '0;
    cnt = 0;
    g = 0;
    got_dir = !t.dir;
    while (g < 200) begin
      step();
      g++;
      if (open_signal) break;
      if (move_up || move_down) begin
        if (cnt == 0) got_dir = dir_up;
        cnt++;
      end
    end
    check($sformatf("trip%0d_open", idx), open_signal, 1);
    check($sformatf("trip%0d_floor", idx), cur_floor, t.target);
    check($sformatf("trip%0d_travel", idx), cnt, t.travel);
    check($sformatf("trip%0d_dir", idx), got_dir, t.dir);
    check($sformatf("trip%0d_clear", idx), req_pending[t.target], 0);
    cnt = 0;
    g = 0;
    while (open_signal && g < 100) begin
      cnt++;
      g++;
      step();
    end
    check($sformatf("trip%0d_hold", idx), cnt, DOOR_HOLD);
    pulse_close();
    wait_idle($sformatf("trip%0d_idle", idx));
  endtask

  initial begin
    trip_t trips[5];
    int    stops[3];
    int    cnt, g;

    trips[0] = '{3, 12, 1'b1};
    trips[1] = '{7, 16, 1'b1};
    trips[2] = '{2, 20, 1'b0};
    trips[3] = '{0,  8, 1'b0};
    trips[4] = '{2,  8, 1'b1};

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    step();
    check("rst_open", open_signal, 0);
    check("rst_move_up", move_up, 0);
    check("rst_move_down", move_down, 0);
    check("rst_floor", cur_floor, 0);
    check("rst_busy", busy, 0);
    check("rst_dir", dir_up, 1);
    check("rst_pending", req_pending, 0);

    foreach (trips[i]) run_trip(trips[i], i);

    // SCAN order from floor 2 heading to 5 with 0 and 6 added en route
    req_in = FLOORS'(1 << 5);
    step();
    req_in = '0;
    step();
    check("scan_moving_up", move_up, 1);
    req_in = FLOORS'((1 << 0) | (1 << 6));
    step();
    req_in = '0;
    for (int k = 0; k < 3; k++) begin
      wait_open(1'b1, 200, $sformatf("scan_stop%0d_open", k));
      stops[k] = cur_floor;
      wait_open(1'b0, 100, $sformatf("scan_stop%0d_close", k));
      pulse_close();
    end
    check("scan_stop0", stops[0], 5);
    check("scan_stop1", stops[1], 6);
    check("scan_stop2", stops[2], 0);
    check("scan_dir_after", dir_up, 0);
    wait_idle("scan_idle");

    // Re-open from CLOSING at floor 4
    req_in = FLOORS'(1 << 4);
    step();
    req_in = '0;
    wait_open(1'b1, 200, "reopen_arrive");
    check("reopen_floor", cur_floor, 4);
    wait_open(1'b0, 100, "reopen_closing");
    step();
    step();
    req_in = FLOORS'(1 << 4);
    step();
    req_in = '0;
    check("reopen_next_cycle", open_signal, 1);
    check("reopen_not_latched", req_pending[4], 0);
    cnt = 0;
    g = 0;
    while (open_signal && g < 100) begin
      cnt++;
      g++;
      step();
    end
    check("reopen_hold", cnt, DOOR_HOLD);
    check("reopen_pend_after", req_pending[4], 0);

    // Close handshake never arrives: forced re-open after the timeout
    cnt = 0;
    g = 0;
    while (!open_signal && g < 200) begin
      cnt++;
      g++;
      step();
    end
    check("timeout_cycles", cnt, CLOSE_TIMEOUT);
    check("timeout_reopen", open_signal, 1);

    // Falling edge and button on the same cycle: re-open wins
    wait_open(1'b0, 100, "tie_closing");
    close_signal = 1'b1;
    repeat (3) step();
    close_signal = 1'b0;
    req_in = FLOORS'(1 << 4);
    step();
    req_in = '0;
    check("tie_reopen", open_signal, 1);
    check("tie_pend", req_pending[4], 0);
    wait_open(1'b0, 100, "tie_close_again");
    pulse_close();
    wait_idle("tie_idle");

    // Reset mid-move at floor 3 with the step counter at 2
    req_in = FLOORS'(1 << 1);
    step();
    req_in = FLOORS'(1 << 6);
    step();
    req_in = '0;
    g = 0;
    while (cur_floor != 3 && g < 100) begin
      step();
      g++;
    end
    check("midmove_floor", cur_floor, 3);
    step();
    step();
    check("midmove_moving", move_down, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midmove_rst_floor", cur_floor, 0);
    check("midmove_rst_up", move_up, 0);
    check("midmove_rst_down", move_down, 0);
    check("midmove_rst_pending", req_pending, 0);
    check("midmove_rst_busy", busy, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      req_in = ($urandom_range(0, 9) == 0) ? FLOORS'(1 << $urandom_range(0, FLOORS - 1))
                                            : '0;
      if ($urandom_range(0, 11) == 0) close_signal = ~close_signal;
      rst = ($urandom_range(0, 799) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lift_scheduler.md
Name: lift_scheduler

Overview:
Floor-request scheduler for the elevator course-design system. It latches hall/car button requests and runs SCAN (elevator) scheduling to decide travel direction. It steps the car floor by floor, then sequences the door. At each stop it drives open_signal to the door-close controller and waits for that controller's close_signal handshake before moving again.

Parameters:
FLOORS, 8, number of floors; floors indexed 0..FLOORS-1
FW, 3, width of floor index; must satisfy 2^FW >= FLOORS
MOVE_TIME, 16, clock cycles to travel one floor (>=1)
DOOR_HOLD, 32, clock cycles open_signal stays high per door opening (>=1)
CLOSE_TIMEOUT, 64, max cycles waiting for the close handshake before forced re-open

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req_in  input  FLOORS  request buttons, bit i = floor i; level, may be held many cycles
close_signal  input  1  from door-close controller; high while door is closing; falling edge = door fully closed
open_signal  output  1  door open drive, level
move_up  output  1  motor up drive
move_down  output  1  motor down drive
cur_floor  output  FW  current floor index
dir_up  output  1  current scan direction, 1 = up
req_pending  output  FLOORS  latched outstanding requests
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: one clock and one synchronous active-high reset. Synchronous reset sampled at posedge clk, rst=1 dominates everything.
- Reset values: state=IDLE, cur_floor=0, dir_up=1, req_pending=0, open_signal=0, move_up=0, move_down=0, all counters=0.
- Reset mid-move or mid-door aborts immediately. No attempt is made to finish the floor step.
- Request latch: each cycle, req_pending <= req_pending | req_in, except for the clear rules below. Decisions use the registered req_pending, so there is 1 cycle of latency from req_in to any action.
- Clear rule: on the edge entering OPEN at floor f, bit f is cleared. A req_in[f] on that same edge is not latched, because it is being served.
- During OPEN or CLOSING, req_in[cur_floor] is never latched; it is handled as a re-open instead.
- above = any req_pending bit > cur_floor; below = any bit < cur_floor; here = req_pending[cur_floor].
- States:
  IDLE: outputs low. Priority order:
    - here -> OPEN.
    - else if dir_up and above -> MOVE.
    - else if !dir_up and below -> MOVE.
    - else if above -> dir_up<=1, MOVE.
    - else if below -> dir_up<=0, MOVE.
    - else stay.
  MOVE: move_up=dir_up, move_down=!dir_up (exactly one high). The counter runs 0..MOVE_TIME-1. On the last count, cur_floor steps by ±1 and the counter clears. Using the new floor:
    - request present there -> OPEN.
    - else continue MOVE.
    - cur_floor never leaves 0..FLOORS-1. A step that would go out of range is impossible by the SCAN rule.
  OPEN: open_signal=1, hold counter runs 0..DOOR_HOLD-1. req_in[cur_floor]=1 restarts the counter at 0. At the end of the count, open_signal drops and the state goes to CLOSING.
  CLOSING: open_signal=0, waiting for the close handshake.
    - Falling edge of close_signal (registered previous value was 1, now 0) -> DECIDE.
    - req_in[cur_floor]=1 before that -> OPEN, counter 0 (re-open).
    - Wait counter reaching CLOSE_TIMEOUT -> OPEN (forced re-open).
    - If the falling edge and req_in[cur_floor] occur on the same cycle, re-open wins.
  DECIDE (1 cycle):
    - continue in dir_up if requests remain in that direction.
    - else reverse if any remain.
    - else IDLE.
    - Entering MOVE from DECIDE starts with counter 0.
- move_up, move_down and open_signal are mutually exclusive in every cycle. The motor is never driven in OPEN or CLOSING.
- req_pending is registered; the other outputs are decoded from the registered state, so there are no combinational paths from the inputs.

Test Plan:
1. rst held 3 cycles then released, no requests -> IDLE, cur_floor=0, all outputs 0, busy=0.
2. MOVE_TIME=4, DOOR_HOLD=8; pulse req_in[3] 1 cycle at floor 0 -> move_up high 12 cycles, cur_floor 1,2,3, then open_signal high exactly 8 cycles and req_pending[3] clears. Model close_signal 1 for 5 cycles then 0 -> IDLE.
3. At floor 2 moving up toward 5, latch requests 0 and 6 -> stops at 5, then 6, reverses, stops at 0; the stop order 5,6,0 must be checked.
4. During CLOSING at floor 4, assert req_in[4] -> open_signal re-asserts the next cycle for a full DOOR_HOLD; req_pending[4] remains 0.
5. Hold close_signal low forever after open -> after CLOSE_TIMEOUT=64 cycles the state re-enters OPEN. Repeat with the falling edge and req_in[cur_floor] on the same cycle -> re-open.
6. Assert rst mid-MOVE (counter=2, floor 3) -> next cycle cur_floor=0, move_up=0, req_pending=0, IDLE.
